mpu_fetch: RTL and testbench
============================

# mpu_fetch

Instruction fetch stage of the MPU, sitting directly downstream of the MPU control interface: it obeys the `mpu_en`/`mpu_rst` pair driven there. It reads 64-bit instruction words from a synchronous program RAM and hands them in order to the MPU decoder through a valid/ready handshake. It raises `error` when execution runs off the end of program memory, which makes the control interface end the run with an error event.

## Interface
- `addr_width`, 9 — program RAM address width; 2^addr_width instruction words.
- `sys_clk` in 1 — single clock (the MPU clock domain).
- `sys_rst` in 1 — synchronous, active-high reset.
- `mpu_en` in 1 — run enable from the control interface; 0 pauses issue.
- `mpu_rst` in 1 — synchronous run restart from the control interface; same effect as `sys_rst`.
- `mem_re` out 1 — RAM read strobe.
- `mem_addr` out addr_width — RAM read address.
- `mem_di` in 64 — RAM read data, valid exactly 1 cycle after `mem_re`.
- `insn_valid` out 1 — head instruction available.
- `insn_ready` in 1 — decoder accepts head; pop = `insn_valid & insn_ready`.
- `insn_data` out 64 — head instruction word.
- `insn_pc` out addr_width — address of the head instruction.
- `jump_en` in 1 — single-cycle redirect from the decoder.
- `jump_addr` in addr_width — redirect target.
- `error` out 1 — sticky fetch fault (runs off the end of program memory).

## Operation
- State: `pc`, 2-entry instruction FIFO (word plus its pc), `inflight` (0/1), `discard` flag, FSM `IDLE`, `RUN`, `END`, `FAULT`.
- Reset (`sys_rst` or `mpu_rst`): `pc`=0, FIFO empty, `inflight`=0, `discard`=0, state `IDLE`.
  - Output values: `mem_re`=0, `mem_addr`=0, `insn_valid`=0, `insn_data`=0, `insn_pc`=0, `error`=0.
- `IDLE` -> `RUN` on `mpu_en`=1.
- Issue condition: state `RUN`, `mpu_en`=1, `jump_en`=0, and (count + inflight − pop) < 2.
  - On issue: `mem_re`=1, `mem_addr`=`pc`, `pc`+=1, `inflight`=1.
- Return: the cycle after an issue, `mem_di` is pushed into the FIFO with its address, unless `discard` is set; in that case the word is dropped and `discard` is cleared.
- Pause: while `mpu_en`=0 nothing is issued. An in-flight word still lands. `insn_valid` is forced to 0 and no pop occurs.
- Redirect (`jump_en`=1, any state except `FAULT`):
  - A pop in the same cycle is honoured first.
  - FIFO is then flushed; `discard` is set if `inflight`=1.
  - `pc` <= `jump_addr`; state `END` -> `RUN`.
  - The first issue at the target is the next cycle.
- End of memory: issuing at address 2^addr_width−1 moves `RUN` -> `END`. No further issue occurs in `END`.
- `END` -> `FAULT` when FIFO is empty, `inflight`=0, `mpu_en`=1 and `jump_en`=0.
- `FAULT`: `error`=1 (registered), no issue, `insn_valid`=0. The fault persists until `sys_rst`/`mpu_rst`.
- Simultaneous events:
  - `jump_en` with `mpu_rst`: reset wins.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - FIFO never overflows; the issue rule guarantees count + inflight ≤ 2.

## Timing
- Issue at cycle N -> `mem_di` sampled at N+1 -> `insn_valid` at N+2.
- First instruction after `mpu_rst` release with `mpu_en`=1: issue on the first enabled cycle; `insn_valid` 2 cycles later.
- Throughput: one instruction per cycle with `insn_ready` held high (steady state count=1, inflight=1).
- Redirect penalty: `jump_en` at cycle J -> target issued J+1 -> target `insn_valid` at J+3.
- `error` rises 1 cycle after the `END` -> `FAULT` condition holds.
- All outputs are registered except `insn_valid`, `insn_data` and `insn_pc`. Those are driven directly from FIFO head registers, gated by `mpu_en` and state.

## Configuration
- `MPU_FETCH_BOUND_CHECK_EN`
  - Defined: end-of-memory behaviour as above (`END`/`FAULT` states, `error` possible).
  - Undefined: `pc` wraps from 2^addr_width−1 to 0 and fetch continues in `RUN`. `END`/`FAULT` are unreachable and `error` is tied to 0.

## Structure
- Shared `mpu.vh`: add `MPU_FETCH_STATE_IDLE/RUN/END/FAULT` encodings (2 bits) and `MPU_INSN_WIDTH` = 64.
- One sub-module, `mpu_fetch_fifo`: 2-entry synchronous FIFO (push, pop, flush, count), width `MPU_INSN_WIDTH` + addr_width.
- The FSM, pc, inflight/discard logic and issue rule stay in `mpu_fetch`.

## Test plan
- Straight-line run: `mpu_rst` pulse, `mpu_en`=1, ready=1, RAM[k]=k+100 -> `insn_data` 100,101,102… on consecutive cycles from cycle 3, `insn_pc` 0,1,2….
- Backpressure: ready=0 for 5 cycles after the first valid -> at most 2 issues outstanding, `mem_re` low while full. On release, the order is preserved with no loss or duplication.
- Redirect with in-flight: `jump_en`, `jump_addr`=0x40 while inflight=1 and count=1 -> stale word dropped, next `insn_pc`=0x40 exactly 3 cycles after `jump_en`.
- Pause: `mpu_en`=0 for 4 cycles mid-stream -> `insn_valid`=0 and no `mem_re` while paused. The stream resumes at the next pc with no gap or repeat.
- End of memory (macro on, addr_width=4): run from 12 without jumps -> instructions 12..15 delivered, then `error`=1 one cycle after the drain. `mpu_rst` clears it. With the macro off, `insn_pc` continues 15,0,1 and `error` stays 0.
- Reset mid-operation: `sys_rst` with count=2 and inflight=1 -> next cycle all outputs are at their reset values and the returning word is ignored.

Source files
------------

// File: rtl/mpu_fetch_pkg.sv
// Shared MPU fetch definitions: instruction word width and fetch FSM state encodings.
package mpu_fetch_pkg;

    localparam int unsigned MPU_INSN_WIDTH        = 64;
    localparam int unsigned MPU_FETCH_STATE_WIDTH = 2;

    localparam logic [MPU_FETCH_STATE_WIDTH-1:0] MPU_FETCH_STATE_IDLE  = 2'd0;
    localparam logic [MPU_FETCH_STATE_WIDTH-1:0] MPU_FETCH_STATE_RUN   = 2'd1;
    localparam logic [MPU_FETCH_STATE_WIDTH-1:0] MPU_FETCH_STATE_END   = 2'd2;
    localparam logic [MPU_FETCH_STATE_WIDTH-1:0] MPU_FETCH_STATE_FAULT = 2'd3;

endpackage

// File: rtl/mpu_fetch_fifo.sv
// Two-entry synchronous FIFO holding fetched instruction words with their addresses.
// Flush has priority over push and pop; simultaneous push and pop keep the count unchanged.
module mpu_fetch_fifo
    import mpu_fetch_pkg::*;
#(
    parameter int unsigned width = MPU_INSN_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             valid,
    output logic [1:0]       count
);

    logic [width-1:0] entry0;
    logic [width-1:0] entry1;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);
    assign dout    = entry0;
    assign valid   = (count != 2'd0);

    // entry0 is always the head; entry1 only holds data when count is 2.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) entry0 <= din;
                    else               entry1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mpu_fetch.sv
// MPU instruction fetch stage: reads program RAM and feeds the decoder over valid/ready.
// MPU_FETCH_BOUND_CHECK_EN: fault when execution runs off the end of memory instead of wrapping.
module mpu_fetch
    import mpu_fetch_pkg::*;
#(
    parameter int unsigned addr_width = 9
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      mpu_en,
    input  logic                      mpu_rst,
    output logic                      mem_re,
    output logic [addr_width-1:0]     mem_addr,
    input  logic [MPU_INSN_WIDTH-1:0] mem_di,
    output logic                      insn_valid,
    input  logic                      insn_ready,
    output logic [MPU_INSN_WIDTH-1:0] insn_data,
    output logic [addr_width-1:0]     insn_pc,
    input  logic                      jump_en,
    input  logic [addr_width-1:0]     jump_addr,
    output logic                      error
);

    localparam int unsigned entry_width = MPU_INSN_WIDTH + addr_width;
`ifdef MPU_FETCH_BOUND_CHECK_EN
    localparam logic [addr_width-1:0] last_addr = '1;
`endif

    logic [MPU_FETCH_STATE_WIDTH-1:0] state;
    logic [MPU_FETCH_STATE_WIDTH-1:0] state_next;
    logic [addr_width-1:0]            pc;
    logic                             inflight;
    logic                             rst;
    logic                             active;
    logic                             issue;
    logic                             flush;
    logic                             push;
    logic                             pop;
    logic [2:0]                       occupancy;
    logic [1:0]                       count;
    logic                             head_valid;
    logic [entry_width-1:0]           head;

    assign rst = sys_rst | mpu_rst;

    mpu_fetch_fifo #(
        .width (entry_width)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({mem_di, mem_addr}),
        .dout  (head),
        .valid (head_valid),
        .count (count)
    );

    // Decoder-facing head comes straight from the FIFO head, masked while paused or faulted.
    assign active     = (state == MPU_FETCH_STATE_RUN) || (state == MPU_FETCH_STATE_END);
    assign insn_valid = active && mpu_en && head_valid;
    assign insn_data  = insn_valid ? head[entry_width-1:addr_width] : '0;
    assign insn_pc    = insn_valid ? head[addr_width-1:0] : '0;
    assign pop        = insn_valid && insn_ready;
    assign mem_re     = inflight;

    always_comb begin
        state_next = state;
        occupancy  = 3'(count) + 3'(inflight) - 3'(pop);
        issue      = (state == MPU_FETCH_STATE_RUN) && mpu_en && !jump_en
                     && (occupancy < 3'd2);
        flush      = jump_en && (state != MPU_FETCH_STATE_FAULT);
        // A word landing during a redirect belongs to the abandoned stream.
        push       = inflight && !flush;

        case (state)
            MPU_FETCH_STATE_IDLE: begin
                if (mpu_en) state_next = MPU_FETCH_STATE_RUN;
            end
            MPU_FETCH_STATE_RUN: begin
`ifdef MPU_FETCH_BOUND_CHECK_EN
                if (issue && (pc == last_addr)) state_next = MPU_FETCH_STATE_END;
`endif
            end
            MPU_FETCH_STATE_END: begin
                if (jump_en) begin
                    state_next = MPU_FETCH_STATE_RUN;
                end else if ((count == 2'd0) && !inflight && mpu_en) begin
                    state_next = MPU_FETCH_STATE_FAULT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) state <= MPU_FETCH_STATE_IDLE;
        else     state <= state_next;
    end

    // Read strobe doubles as the in-flight marker: data returns while it is high.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pc       <= '0;
            inflight <= 1'b0;
            mem_addr <= '0;
        end else begin
            inflight <= issue;
            if (issue) mem_addr <= pc;
            if (flush)      pc <= jump_addr;
            else if (issue) pc <= pc + addr_width'(1);
        end
    end

`ifdef MPU_FETCH_BOUND_CHECK_EN
    always_ff @(posedge sys_clk) begin
        if (rst) error <= 1'b0;
        else     error <= (state_next == MPU_FETCH_STATE_FAULT);
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mpu_fetch.sv
// Directed self-checking bench for mpu_fetch; expectations follow MPU_FETCH_BOUND_CHECK_EN.
module tb_mpu_fetch;
    import mpu_fetch_pkg::*;

    localparam int unsigned aw = 9;

    logic                      sys_clk    = 1'b0;
    logic                      sys_rst    = 1'b0;
    logic                      mpu_en     = 1'b0;
    logic                      mpu_rst    = 1'b0;
    logic                      insn_ready = 1'b0;
    logic                      jump_en    = 1'b0;
    logic [aw-1:0]             jump_addr  = '0;
    logic                      mem_re;
    logic [aw-1:0]             mem_addr;
    logic [MPU_INSN_WIDTH-1:0] mem_di;
    logic                      insn_valid;
    logic [MPU_INSN_WIDTH-1:0] insn_data;
    logic [aw-1:0]             insn_pc;
    logic                      error;
    logic [MPU_INSN_WIDTH-1:0] ram [0:(1<<aw)-1];
    int                        checks   = 0;
    int                        failures = 0;

    mpu_fetch #(.addr_width(aw)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .mpu_en     (mpu_en),
        .mpu_rst    (mpu_rst),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_di     (mem_di),
        .insn_valid (insn_valid),
        .insn_ready (insn_ready),
        .insn_data  (insn_data),
        .insn_pc    (insn_pc),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .error      (error)
    );

    always #5 sys_clk = ~sys_clk;

    // RAM read port: the address register is the fetch stage's mem_addr, data follows the strobe.
    assign mem_di = mem_re ? ram[mem_addr] : 64'hdead_beef_dead_beef;

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: first cycle after an mpu_rst pulse, enable and ready high.
    task automatic start_run();
        next_cycle();
        mpu_rst    = 1'b1;
        mpu_en     = 1'b1;
        insn_ready = 1'b1;
        jump_en    = 1'b0;
        next_cycle();
        mpu_rst    = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        sys_rst    = 1'b1;
        mpu_en     = 1'b1;
        insn_ready = 1'b1;
        next_cycle();
        sys_rst = 1'b0;
        mpu_en  = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (mem_re !== 1'b0) begin failures++; $display("FAIL reset_mem_re got=%b want=0", mem_re); end
        checks++;
        if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%0h want=0", mem_addr); end
        checks++;
        if (insn_valid !== 1'b0) begin failures++; $display("FAIL reset_insn_valid got=%b want=0", insn_valid); end
        checks++;
        if (insn_data !== '0) begin failures++; $display("FAIL reset_insn_data got=%0h want=0", insn_data); end
        checks++;
        if (insn_pc !== '0) begin failures++; $display("FAIL reset_insn_pc got=%0h want=0", insn_pc); end
        checks++;
        if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b want=0", error); end
    endtask

    task automatic test_straight();
        logic [aw-1:0]             ep;
        logic [MPU_INSN_WIDTH-1:0] ed;
        start_run();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            @(negedge sys_clk);
            checks++;
            ep = aw'(c - 2);
            if (c < 2) begin
                if (mem_re !== 1'b0) begin failures++; $display("FAIL straight_re c=%0d got=%b want=0", c, mem_re); end
            end else if ({mem_re, mem_addr} !== {1'b1, ep}) begin
                failures++;
                $display("FAIL straight_re c=%0d got re=%b addr=%0d want re=1 addr=%0d", c, mem_re, mem_addr, ep);
            end
            checks++;
            ep = aw'(c - 3);
            ed = 64'(ep) + 64'd100;
            if (c < 3) begin
                if (insn_valid !== 1'b0) begin failures++; $display("FAIL straight_valid c=%0d got=%b want=0", c, insn_valid); end
            end else if ({insn_valid, insn_pc, insn_data} !== {1'b1, ep, ed}) begin
                failures++;
                $display("FAIL straight_insn c=%0d got v=%b pc=%0d data=%0d want v=1 pc=%0d data=%0d", c, insn_valid, insn_pc, insn_data, ep, ed);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [aw-1:0]             ep;
        logic [MPU_INSN_WIDTH-1:0] ed;
        start_run();
        for (int c = 1; c <= 14; c++) begin
            next_cycle();
            if (c == 3) insn_ready = 1'b0;
            if (c == 8) insn_ready = 1'b1;
            @(negedge sys_clk);
            if (c >= 4 && c <= 8) begin
                checks++;
                if (mem_re !== 1'b0) begin failures++; $display("FAIL bp_re_full c=%0d got=%b want=0", c, mem_re); end
            end
            if (c >= 3) begin
                ep = (c <= 8) ? aw'(0) : aw'(c - 8);
                ed = 64'(ep) + 64'd100;
                checks++;
                if ({insn_valid, insn_pc, insn_data} !== {1'b1, ep, ed}) begin
                    failures++;
                    $display("FAIL bp_order c=%0d got v=%b pc=%0d data=%0d want v=1 pc=%0d data=%0d", c, insn_valid, insn_pc, insn_data, ep, ed);
                end
            end
        end
    endtask

    task automatic test_redirect();
        logic [aw-1:0]             ep;
        logic [MPU_INSN_WIDTH-1:0] ed;
        start_run();
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            jump_en = (c == 5);
            if (c == 5) jump_addr = aw'(9'h040);
            @(negedge sys_clk);
            if (c == 5 || c >= 8) begin
                ep = (c == 5) ? aw'(2) : aw'(9'h040 + c - 8);
                ed = 64'(ep) + 64'd100;
                checks++;
                if ({insn_valid, insn_pc, insn_data} !== {1'b1, ep, ed}) begin
                    failures++;
                    $display("FAIL jump_insn c=%0d got v=%b pc=%0h data=%0d want v=1 pc=%0h data=%0d", c, insn_valid, insn_pc, insn_data, ep, ed);
                end
            end
            if (c == 6 || c == 7) begin
                checks++;
                if (insn_valid !== 1'b0) begin failures++; $display("FAIL jump_bubble c=%0d got valid=%b want=0", c, insn_valid); end
            end
            if (c == 6) begin
                checks++;
                if (mem_re !== 1'b0) begin failures++; $display("FAIL jump_no_issue c=%0d got re=%b want=0", c, mem_re); end
            end
            if (c == 7) begin
                checks++;
                if ({mem_re, mem_addr} !== {1'b1, aw'(9'h040)}) begin
                    failures++;
                    $display("FAIL jump_target_re c=%0d got re=%b addr=%0h want re=1 addr=40", c, mem_re, mem_addr);
                end
            end
        end
    endtask

    task automatic test_pause();
        logic [aw-1:0]             ep;
        logic [MPU_INSN_WIDTH-1:0] ed;
        start_run();
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            if (c == 5) mpu_en = 1'b0;
            if (c == 9) mpu_en = 1'b1;
            @(negedge sys_clk);
            if (c >= 5 && c <= 8) begin
                checks++;
                if (insn_valid !== 1'b0) begin failures++; $display("FAIL pause_valid c=%0d got=%b want=0", c, insn_valid); end
            end
            // mem_re is registered, so it trails the paused window by one cycle.
            if (c >= 6 && c <= 9) begin
                checks++;
                if (mem_re !== 1'b0) begin failures++; $display("FAIL pause_re c=%0d got=%b want=0", c, mem_re); end
            end
            if (c == 4 || c >= 9) begin
                ep = (c == 4) ? aw'(1) : aw'(c - 7);
                ed = 64'(ep) + 64'd100;
                checks++;
                if ({insn_valid, insn_pc, insn_data} !== {1'b1, ep, ed}) begin
                    failures++;
                    $display("FAIL pause_stream c=%0d got v=%b pc=%0d data=%0d want v=1 pc=%0d data=%0d", c, insn_valid, insn_pc, insn_data, ep, ed);
                end
            end
        end
    endtask

    task automatic test_end_of_mem();
        logic [aw-1:0]             ep;
        logic [MPU_INSN_WIDTH-1:0] ed;
        start_run();
        for (int c = 1; c <= 11; c++) begin
            next_cycle();
            jump_en = (c == 3);
            if (c == 3) jump_addr = aw'(9'h1fc);
            @(negedge sys_clk);
            if (c >= 6 && c <= 9) begin
                ep = aw'(9'h1fc + c - 6);
                ed = 64'(ep) + 64'd100;
                checks++;
                if ({insn_valid, insn_pc, insn_data} !== {1'b1, ep, ed}) begin
                    failures++;
                    $display("FAIL eom_tail c=%0d got v=%b pc=%0h data=%0d want v=1 pc=%0h data=%0d", c, insn_valid, insn_pc, insn_data, ep, ed);
                end
            end
`ifdef MPU_FETCH_BOUND_CHECK_EN
            if (c == 9) begin
                checks++;
                if (mem_re !== 1'b0) begin failures++; $display("FAIL eom_no_issue c=%0d got re=%b want=0", c, mem_re); end
            end
            if (c == 10) begin
                checks++;
                if ({insn_valid, error} !== 2'b00) begin failures++; $display("FAIL eom_drain c=%0d got v=%b err=%b want v=0 err=0", c, insn_valid, error); end
            end
            if (c == 11) begin
                checks++;
                if ({insn_valid, error, mem_re} !== 3'b010) begin
                    failures++;
                    $display("FAIL eom_fault c=%0d got v=%b err=%b re=%b want v=0 err=1 re=0", c, insn_valid, error, mem_re);
                end
            end
`else
            if (c >= 10) begin
                ep = aw'(c - 10);
                ed = 64'(ep) + 64'd100;
                checks++;
                if ({insn_valid, insn_pc, insn_data, error} !== {1'b1, ep, ed, 1'b0}) begin
                    failures++;
                    $display("FAIL eom_wrap c=%0d got v=%b pc=%0h data=%0d err=%b want v=1 pc=%0h data=%0d err=0", c, insn_valid, insn_pc, insn_data, error, ep, ed);
                end
            end
`endif
        end
        next_cycle();
        mpu_rst = 1'b1;
        next_cycle();
        mpu_rst = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({error, insn_valid} !== 2'b00) begin failures++; $display("FAIL eom_clear got err=%b v=%b want err=0 v=0", error, insn_valid); end
    endtask

    task automatic test_reset_mid();
        start_run();
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            sys_rst = (c == 3);
            if (c == 3) insn_ready = 1'b0;
            if (c == 5) insn_ready = 1'b1;
            @(negedge sys_clk);
            if (c == 4) begin
                checks++;
                if ({mem_re, mem_addr, insn_valid, insn_data, insn_pc, error} !== '0) begin
                    failures++;
                    $display("FAIL midrst_outputs got re=%b addr=%0h v=%b data=%0h pc=%0h err=%b want all 0", mem_re, mem_addr, insn_valid, insn_data, insn_pc, error);
                end
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (insn_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale c=%0d got v=%b want=0", c, insn_valid); end
            end
            if (c == 7) begin
                checks++;
                if ({insn_valid, insn_pc, insn_data} !== {1'b1, aw'(0), 64'd100}) begin
                    failures++;
                    $display("FAIL midrst_restart got v=%b pc=%0d data=%0d want v=1 pc=0 data=100", insn_valid, insn_pc, insn_data);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < (1 << aw); k++) ram[k] = 64'(k + 100);
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect();
        test_pause();
        test_end_of_mem();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish checks=%0d", checks);
        $fatal(1, "tb_mpu_fetch watchdog expired");
    end

endmodule
